driver_dac: RTL

DRIVER_DAC -- requirements
Module: driver_dac

---
 rtl/driver_dac.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/driver_dac.sv
// Direct-digital-synthesis DAC driver: phase accumulator, waveform shaping, amplitude scaling.
// Optional table waveform (Wave_Sel=3) is enabled by defining DRIVER_DAC_TABLE_EN.
module driver_dac #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned PHASE_W = 24
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic               Stop,
  input  logic [PHASE_W-1:0] Freq_Word,
  input  logic               Freq_Valid,
  output logic               Freq_Ready,
  input  logic [1:0]         Wave_Sel,
  input  logic [7:0]         Amplitude,
  output logic [7:0]         Table_Addr,
  input  logic [7:0]         Table_Data,
  output logic               clk_DAC,
  output logic               DAC_En,
  output logic [7:0]         DAC_Data,
  output logic               Busy,
  output logic               Wrap
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned HALF  = CLK_DIV / 2;

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               clk_dac_q, clk_dac_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] active_q, active_d;
  logic [PHASE_W-1:0] pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [7:0]         samp_q, samp_d;
  logic               s1_q, s2_q;
  logic [7:0]         dac_q, dac_d;
  logic               en_q, en_d;

  logic               busy, tick, run_tick, carry, wrap, xfer;
  logic [PHASE_W-1:0] sum;
  logic [7:0]         w, scaled;
  logic [16:0]        prod;
  logic               unused_bits;

  assign busy     = (state_q != StIdle);
  assign tick     = (div_q == '0);
  assign run_tick = tick & busy;
  assign {carry, sum} = {1'b0, phase_q} + {1'b0, active_q};
  assign wrap     = run_tick & carry & Rst;
  assign xfer     = Freq_Valid & ~pend_vld_q;

  always_comb begin
    div_d     = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    clk_dac_d = (div_d >= DIV_W'(HALF));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (tick && Start && !Stop) state_d = StRun;
      StRun:      if (Stop) state_d = StStopping;
      StStopping: if (wrap) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Phase is forced to zero in IDLE, including the wrap that returns there.
  always_comb begin
    phase_d = phase_q;
    if (!busy) begin
      phase_d = '0;
    end else if (run_tick) begin
      phase_d = (state_d == StIdle) ? '0 : sum;
    end
  end

  // A word captured on a wrap clk is only applied at the following wrap.
  always_comb begin
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (pend_vld_q && (!busy || wrap)) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end
    if (xfer) begin
      pend_d     = Freq_Word;
      pend_vld_d = 1'b1;
    end
  end

  assign samp_d = run_tick ? phase_q[PHASE_W-1 -: 8] : samp_q;

  always_comb begin
    w = samp_q;
    case (Wave_Sel)
      2'd0: w = samp_q;
      2'd1: w = samp_q[7] ? ~{samp_q[6:0], 1'b0} : {samp_q[6:0], 1'b0};
      2'd2: w = {8{samp_q[7]}};
`ifdef DRIVER_DAC_TABLE_EN
      2'd3: w = Table_Data;
`else
      2'd3: w = samp_q;
`endif
      default: w = samp_q;
    endcase
  end

  assign prod   = {9'd0, w} * {8'd0, ({1'b0, Amplitude} + 9'd1)};
  assign scaled = prod[15:8];

  // Sample lands two clks after its tick so Table_Data has settled.
  always_comb begin
    dac_d = dac_q;
    if (state_d == StIdle) begin
      dac_d = 8'h80;
    end else if (s2_q) begin
      dac_d = scaled;
    end
    en_d = busy && (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      clk_dac_q  <= 1'b0;
      phase_q    <= '0;
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      samp_q     <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      dac_q      <= 8'h80;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      clk_dac_q  <= clk_dac_d;
      phase_q    <= phase_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      samp_q     <= samp_d;
      s1_q       <= run_tick;
      s2_q       <= s1_q;
      dac_q      <= dac_d;
      en_q       <= en_d;
    end
  end

`ifdef DRIVER_DAC_TABLE_EN
  assign Table_Addr  = samp_q;
  assign unused_bits = ^{prod[16], prod[7:0]};
`else
  assign Table_Addr  = 8'h00;
  assign unused_bits = ^{prod[16], prod[7:0], Table_Data};
`endif

  assign Freq_Ready = ~pend_vld_q;
  assign clk_DAC    = clk_dac_q;
  assign DAC_En     = en_q;
  assign DAC_Data   = dac_q;
  assign Busy       = busy;
  assign Wrap       = wrap;

endmodule
